vdp_vga_upscan: RTL

//  Line doubler downstream of vdp_ssg: converts the 15 kHz VDP raster into 31 kHz VGA timing.

---
 rtl/vdp_vga_pkg.sv | 21 ++
 rtl/vdp_vga_upscan_if.sv | 31 +++
 rtl/vdp_vga_line_buf.sv | 33 +++
 rtl/vdp_vga_upscan.sv | 105 ++++++++++
 4 files changed

// File: rtl/vdp_vga_pkg.sv
// Shared types and helpers for the VDP 15 kHz -> VGA 31 kHz line doubler.
package vdp_vga_pkg;

  localparam int LBUF_AW = 10;

  typedef struct packed {
    logic [5:0] r;
    logic [5:0] g;
    logic [5:0] b;
  } rgb18_t;

  function automatic logic [LBUF_AW-1:0] vga_half_pos(
    input logic [10:0] h,
    input int          total
  );
    logic [10:0] half;
    half = 11'(total / 2);
    return LBUF_AW'((h < half) ? h : h - half);
  endfunction

endpackage

// File: rtl/vdp_vga_upscan_if.sv
// Video bundle between vdp_ssg/colour stage and the line doubler outputs.
interface vdp_vga_upscan_if;

  logic        enable;
  logic [10:0] h_cnt;
  logic        vd;
  logic [5:0]  pix_r;
  logic [5:0]  pix_g;
  logic [5:0]  pix_b;
  logic [5:0]  vga_r;
  logic [5:0]  vga_g;
  logic [5:0]  vga_b;
  logic        vga_hs_n;
  logic        vga_vs_n;
  logic        vga_de;

  modport master (
    output enable, h_cnt, vd,
    output pix_r, pix_g, pix_b,
    input  vga_r, vga_g, vga_b,
    input  vga_hs_n, vga_vs_n, vga_de
  );

  modport slave (
    input  enable, h_cnt, vd,
    input  pix_r, pix_g, pix_b,
    output vga_r, vga_g, vga_b,
    output vga_hs_n, vga_vs_n, vga_de
  );

endinterface

// File: rtl/vdp_vga_line_buf.sv
// Ping-pong line buffer: one write port, one registered read port.
module vdp_vga_line_buf
  import vdp_vga_pkg::*;
(
  input  logic               clk,
  input  logic               we_i,
  input  logic               wbank_i,
  input  logic [LBUF_AW-1:0] waddr_i,
  input  rgb18_t             wdata_i,
  input  logic               re_i,
  input  logic               rbank_i,
  input  logic [LBUF_AW-1:0] raddr_i,
  output rgb18_t             rdata_o
);

  localparam int DEPTH = 2 ** (LBUF_AW + 1);

  rgb18_t mem_q [DEPTH];
  rgb18_t rdata_q;

  // No reset, so the array maps onto block RAM
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[{wbank_i, waddr_i}] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[{rbank_i, raddr_i}];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/vdp_vga_upscan.sv
// VDP line doubler: each captured line replays twice at 31 kHz.
// Optional VDP_VGA_SCANLINE_EN halves intensity on the second replay.
module vdp_vga_upscan
  import vdp_vga_pkg::*;
#(
  parameter int H_TOTAL  = 1368,
  parameter int HS_WIDTH = 82,
  parameter int DE_START = 96,
  parameter int DE_WIDTH = 560
) (
  input  logic             clk,
  input  logic             reset_n,
  vdp_vga_upscan_if.slave  vif
);

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [LBUF_AW-1:0] HS_END = LBUF_AW'(HS_WIDTH);
  localparam logic [LBUF_AW-1:0] DE_LO = LBUF_AW'(DE_START);
  localparam logic [LBUF_AW-1:0] DE_HI =
    LBUF_AW'(DE_START + DE_WIDTH);

  logic               bank_q, bank_d;
  logic               vd_line_q, vd_line_d;
  logic [LBUF_AW-1:0] out_h, oh_q;
  rgb18_t             wr_pix, rd_pix;
  rgb18_t             rgb_q, rgb_d;
  logic               hs_n_q, hs_n_d;
  logic               vs_n_q, vs_n_d;
  logic               de_q, de_d;
`ifdef VDP_VGA_SCANLINE_EN
  localparam logic [10:0] H_HALF = 11'(H_TOTAL / 2);
  logic               half_q;
`endif

  vdp_vga_line_buf u_lbuf (
    .clk     (clk),
    .we_i    (vif.enable && vif.h_cnt[0]),
    .wbank_i (bank_q),
    .waddr_i (vif.h_cnt[10:1]),
    .wdata_i (wr_pix),
    .re_i    (vif.enable),
    .rbank_i (~bank_q),
    .raddr_i (out_h),
    .rdata_o (rd_pix)
  );

  always_comb begin
    out_h     = vga_half_pos(vif.h_cnt, H_TOTAL);
    wr_pix    = '{r: vif.pix_r, g: vif.pix_g, b: vif.pix_b};
    bank_d    = bank_q;
    vd_line_d = vd_line_q;
    if (vif.h_cnt == H_LAST) begin
      bank_d    = ~bank_q;
      vd_line_d = vif.vd;
    end
    hs_n_d = !(oh_q < HS_END);
    de_d   = (oh_q >= DE_LO) && (oh_q < DE_HI);
    vs_n_d = ~vd_line_q;
    rgb_d  = '0;
    if (de_d) begin
      rgb_d = rd_pix;
`ifdef VDP_VGA_SCANLINE_EN
      if (half_q) begin
        rgb_d.r = {1'b0, rd_pix.r[5:1]};
        rgb_d.g = {1'b0, rd_pix.g[5:1]};
        rgb_d.b = {1'b0, rd_pix.b[5:1]};
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bank_q    <= 1'b0;
      vd_line_q <= 1'b0;
      oh_q      <= '0;
      rgb_q     <= '0;
      hs_n_q    <= 1'b1;
      vs_n_q    <= 1'b1;
      de_q      <= 1'b0;
`ifdef VDP_VGA_SCANLINE_EN
      half_q    <= 1'b0;
`endif
    end else if (vif.enable) begin
      bank_q    <= bank_d;
      vd_line_q <= vd_line_d;
      oh_q      <= out_h;
      rgb_q     <= rgb_d;
      hs_n_q    <= hs_n_d;
      vs_n_q    <= vs_n_d;
      de_q      <= de_d;
`ifdef VDP_VGA_SCANLINE_EN
      half_q    <= (vif.h_cnt >= H_HALF);
`endif
    end
  end

  assign vif.vga_r    = rgb_q.r;
  assign vif.vga_g    = rgb_q.g;
  assign vif.vga_b    = rgb_q.b;
  assign vif.vga_hs_n = hs_n_q;
  assign vif.vga_vs_n = vs_n_q;
  assign vif.vga_de   = de_q;

endmodule
